// File: rtl/rat_pkg.sv
// rat_pkg: shared types and constants for the rat maze path player.
//   move_t   - 2-bit move opcode; opposite moves are bitwise complements.
//   state_t  - player FSM states.
//   MAZE_MAX - largest coordinate for the default 16x16 maze.
package rat_pkg;

  localparam int COORD_W_DEFAULT = 4;
  localparam int MAZE_MAX        = (1 << COORD_W_DEFAULT) - 1;

  typedef enum logic [1:0] {
    MV_UP    = 2'b00,  // y - 1
    MV_RIGHT = 2'b01,  // x + 1
    MV_LEFT  = 2'b10,  // x - 1
    MV_DOWN  = 2'b11   // y + 1
  } move_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    APPLY,
    HOLD,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/rat_step_calc.sv
// rat_step_calc: combinational single-step position update.
//   x, y         in  current position
//   mv           in  move to apply
//   new_x, new_y out position after the move (wraps modulo 2^COORD_W)
//   oob          out the move would leave the maze
module rat_step_calc
  import rat_pkg::*;
#(
  parameter int COORD_W = 4
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  move_t              mv,
  output logic [COORD_W-1:0] new_x,
  output logic [COORD_W-1:0] new_y,
  output logic               oob
);

  localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);
  localparam logic [COORD_W-1:0] C_MAX = '1;

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    new_x = x;
    new_y = y;
    oob   = 1'b0;
    unique case (mv)
      MV_UP: begin
        new_y = y - C_ONE;
        oob   = (y == '0);
      end
      MV_RIGHT: begin
        new_x = x + C_ONE;
        oob   = (x == C_MAX);
      end
      MV_LEFT: begin
        new_x = x - C_ONE;
        oob   = (x == '0);
      end
      MV_DOWN: begin
        new_y = y + C_ONE;
        oob   = (y == C_MAX);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rat_path_player.sv
// rat_path_player: replays the rat solver's move queue from the maze origin,
// holding each position for HOLD_CYCLES cycles so it can be displayed.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a replay (only honoured in IDLE)
//   mv_valid/mv_data  move queue head; mv_ready is its pop strobe
//   pos_x, pos_y      current replay position
//   pos_strobe        one-cycle pulse when the position takes a new value
//   step_count        moves applied since start, saturating
//   busy              high while fetching, applying or holding
//   arrived           sticky; reached the far corner (goal)
//   err               sticky; illegal move seen (bounds check build only)
//
// Build option: define RAT_PLAYER_BOUNDS_CHECK_EN to reject moves that would
// leave the maze (enter ERR, set err). Without it coordinates wrap and err
// is tied low.
module rat_path_player
  import rat_pkg::*;
#(
  parameter int COORD_W     = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STEP_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mv_valid,
  input  logic [1:0]         mv_data,
  output logic               mv_ready,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               pos_strobe,
  output logic [STEP_W-1:0]  step_count,
  output logic               busy,
  output logic               arrived,
  output logic               err
);

  // APPLY counts as the first held cycle, so HOLD itself lasts
  // HOLD_CYCLES-1 cycles; handshake-to-next-fetch is 1 + HOLD_CYCLES.
  localparam int CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES - 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    CNT_W'((HOLD_CYCLES >= 2) ? HOLD_CYCLES - 2 : 0);

  state_t              state_q,   state_d;
  move_t               move_q,    move_d;
  logic [COORD_W-1:0]  pos_x_q,   pos_x_d;
  logic [COORD_W-1:0]  pos_y_q,   pos_y_d;
  logic                strobe_q,  strobe_d;
  logic [STEP_W-1:0]   step_q,    step_d;
  logic                arrived_q, arrived_d;
  logic [CNT_W-1:0]    hold_q,    hold_d;

  logic [COORD_W-1:0]  new_x, new_y;
  logic                at_goal;

`ifdef RAT_PLAYER_BOUNDS_CHECK_EN
  logic                err_q, err_d;
  logic                step_oob;
`else
  logic                step_oob_unused;
`endif

  rat_step_calc #(
    .COORD_W (COORD_W)
  ) u_step_calc (
    .x     (pos_x_q),
    .y     (pos_y_q),
    .mv    (move_q),
    .new_x (new_x),
    .new_y (new_y),
`ifdef RAT_PLAYER_BOUNDS_CHECK_EN
    .oob   (step_oob)
`else
    .oob   (step_oob_unused)
`endif
  );

  assign at_goal = (new_x == '1) && (new_y == '1);

  always_comb begin
    state_d   = state_q;
    move_d    = move_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    strobe_d  = 1'b0;
    step_d    = step_q;
    arrived_d = arrived_q;
    hold_d    = hold_q;
`ifdef RAT_PLAYER_BOUNDS_CHECK_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pos_x_d   = '0;
          pos_y_d   = '0;
          step_d    = '0;
          arrived_d = 1'b0;
`ifdef RAT_PLAYER_BOUNDS_CHECK_EN
          err_d     = 1'b0;
`endif
          strobe_d  = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (mv_valid) begin
          move_d  = move_t'(mv_data);
          state_d = APPLY;
        end
      end
      APPLY: begin
`ifdef RAT_PLAYER_BOUNDS_CHECK_EN
        if (step_oob) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else
`endif
        begin
          pos_x_d  = new_x;
          pos_y_d  = new_y;
          strobe_d = 1'b1;
          step_d   = (step_q == '1) ? step_q : step_q + STEP_W'(1);
          hold_d   = HOLD_LOAD;
          if (at_goal) begin
            arrived_d = 1'b1;
            state_d   = DONE;
          end else if (HOLD_CYCLES == 1) begin
            state_d = FETCH;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (hold_q == '0) state_d = FETCH;
        else              hold_d  = hold_q - CNT_W'(1);
      end
      // DONE, and ERR when the bounds check is built, last one cycle.
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      move_q    <= MV_UP;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      strobe_q  <= 1'b0;
      step_q    <= '0;
      arrived_q <= 1'b0;
      hold_q    <= '0;
`ifdef RAT_PLAYER_BOUNDS_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      move_q    <= move_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      strobe_q  <= strobe_d;
      step_q    <= step_d;
      arrived_q <= arrived_d;
      hold_q    <= hold_d;
`ifdef RAT_PLAYER_BOUNDS_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  // Pop strobe follows mv_valid only in FETCH; leaving FETCH on the
  // handshake guarantees a single pop per move.
  assign mv_ready   = (state_q == FETCH) && mv_valid;
  assign busy       = (state_q == FETCH) || (state_q == APPLY) || (state_q == HOLD);
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign pos_strobe = strobe_q;
  assign step_count = step_q;
  assign arrived    = arrived_q;
`ifdef RAT_PLAYER_BOUNDS_CHECK_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_rat_path_player.sv
// Directed testbench for rat_path_player (HOLD_CYCLES = 2, 16x16 maze).
// Snapshots pack {pos_x, pos_y, step_count, busy, arrived, err, pos_strobe,
// mv_ready} and are compared with hand-computed expectations.
module tb_rat_path_player;
  import rat_pkg::*;

  localparam int COORD_W = 4;
  localparam int HOLD    = 2;
  localparam int STEP_W  = 8;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic               mv_valid;
  logic [1:0]         mv_data;
  logic               mv_ready;
  logic [COORD_W-1:0] pos_x, pos_y;
  logic               pos_strobe;
  logic [STEP_W-1:0]  step_count;
  logic               busy, arrived, err;

  int n_checks = 0;
  int n_fail   = 0;

  rat_path_player #(
    .COORD_W     (COORD_W),
    .HOLD_CYCLES (HOLD),
    .STEP_W      (STEP_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mv_valid   (mv_valid),
    .mv_data    (mv_data),
    .mv_ready   (mv_ready),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_strobe (pos_strobe),
    .step_count (step_count),
    .busy       (busy),
    .arrived    (arrived),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Move source model: array plus read index derived from pops seen.
  logic [1:0] mv_mem [0:63];
  int   mv_len  = 0;
  int   mv_base = 0;
  int   pop_cnt = 0;
  int   mv_idx;
  logic src_en  = 1'b0;
  int   cyc = 0, last_pop_cyc = 0, prev_pop_cyc = 0;
  logic ready_prev = 1'b0, consec_seen = 1'b0;

  always_comb begin
    mv_idx   = pop_cnt - mv_base;
    mv_valid = src_en && (mv_idx < mv_len);
    mv_data  = mv_mem[mv_idx[5:0]];
  end

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    ready_prev <= mv_ready;
    if (mv_ready && ready_prev) consec_seen <= 1'b1;
    if (mv_ready) begin
      pop_cnt      <= pop_cnt + 1;
      prev_pop_cyc <= last_pop_cyc;
      last_pop_cyc <= cyc;
    end
  end

  function automatic logic [20:0] snap();
    return {pos_x, pos_y, step_count, busy, arrived, err, pos_strobe, mv_ready};
  endfunction

  function automatic logic [20:0] exp_s(input int x, input int y, input int s,
                                        input logic b, input logic a, input logic e,
                                        input logic st, input logic r);
    return {4'(x), 4'(y), 8'(s), b, a, e, st, r};
  endfunction

  function automatic int pops();
    return pop_cnt - mv_base;
  endfunction

  task automatic clear_moves();
    mv_base = pop_cnt;
    mv_len  = 0;
  endtask

  task automatic push_move(input logic [1:0] m);
    mv_mem[mv_len] = m;
    mv_len++;
  endtask

  // Returns at the negedge after the posedge that samples start (cycle N0).
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; src_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_pops(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (pops() >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  logic [20:0] got, want;

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    got = snap(); want = '0; n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_asserted: got %h want %h", got, want); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got = snap(); want = '0; n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_released: got %h want %h", got, want); end
  endtask

  task automatic test_basic_replay();
    clear_moves(); push_move(2'b01); push_move(2'b11);
    src_en = 1'b1;
    pulse_start();  // N0
    got = snap(); want = exp_s(0, 0, 0, 1, 0, 0, 1, 1); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL basic_start: got %h want %h", got, want); end
    repeat (2) @(negedge clk);  // N2
    got = snap(); want = exp_s(1, 0, 1, 1, 0, 0, 1, 0); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL basic_step1: got %h want %h", got, want); end
    @(negedge clk);  // N3: back in FETCH
    got = snap(); want = exp_s(1, 0, 1, 1, 0, 0, 0, 1); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL basic_refetch: got %h want %h", got, want); end
    repeat (2) @(negedge clk);  // N5
    got = snap(); want = exp_s(1, 1, 2, 1, 0, 0, 1, 0); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL basic_step2: got %h want %h", got, want); end
    repeat (5) @(negedge clk);  // N10: waiting in FETCH on an empty queue
    got = snap(); want = exp_s(1, 1, 2, 1, 0, 0, 0, 0); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL basic_idle_fetch: got %h want %h", got, want); end
    n_checks++;
    if (pops() !== 2) begin n_fail++; $display("FAIL basic_pop_count: got %0d want 2", pops()); end
    n_checks++;
    if (last_pop_cyc - prev_pop_cyc !== 3) begin
      n_fail++; $display("FAIL basic_pop_spacing: got %0d want 3", last_pop_cyc - prev_pop_cyc);
    end
  endtask

  task automatic test_stall();
    int bad;
    bad = 0;
    clear_moves(); push_move(2'b10);
    src_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mv_ready !== 1'b0 || pos_x !== 4'd1 || pos_y !== 4'd1) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
    @(negedge clk);
    src_en = 1'b1;
    #1;
    n_checks++;
    if (mv_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready: got %b want 1", mv_ready); end
    repeat (2) @(negedge clk);
    got = snap(); want = exp_s(0, 1, 3, 1, 0, 0, 1, 0); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL stall_left: got %h want %h", got, want); end
    n_checks++;
    if (pops() !== 1) begin n_fail++; $display("FAIL stall_pop_count: got %0d want 1", pops()); end
  endtask

  task automatic test_reset_mid_hold();
    bit ok;
    do_reset();
    clear_moves();
    push_move(2'b01); push_move(2'b01); push_move(2'b01);
    push_move(2'b11); push_move(2'b11);
    src_en = 1'b1;
    pulse_start();
    wait_pops(5, 40, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midhold_timeout: got %0d pops want 5", pops()); end
    @(negedge clk);  // HOLD at (3,2)
    got = snap(); want = exp_s(3, 2, 5, 1, 0, 0, 1, 0); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL midhold_pos: got %h want %h", got, want); end
    #2 rst_n = 1'b0;
    #1;
    got = snap(); want = '0; n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL midhold_async_reset: got %h want %h", got, want); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_moves(); push_move(2'b11);
    pulse_start();
    got = snap(); want = exp_s(0, 0, 0, 1, 0, 0, 1, 1); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL midhold_restart: got %h want %h", got, want); end
    wait_pops(1, 10, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midhold_restart_timeout: got %0d pops want 1", pops()); end
    @(negedge clk);
    got = snap(); want = exp_s(0, 1, 1, 1, 0, 0, 1, 0); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL midhold_replay: got %h want %h", got, want); end
  endtask

  task automatic test_goal();
    bit ok;
    do_reset();
    clear_moves();
    for (int i = 0; i < 15; i++) push_move(2'b01);
    for (int i = 0; i < 15; i++) push_move(2'b11);
    push_move(2'b01);  // extra move that must stay queued
    src_en = 1'b1;
    pulse_start();
    wait_pops(30, 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL goal_timeout: got %0d pops want 30", pops()); end
    got = snap(); want = exp_s(MAZE_MAX, MAZE_MAX - 1, 29, 1, 0, 0, 0, 0); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL goal_last_apply: got %h want %h", got, want); end
    @(negedge clk);  // DONE
    got = snap(); want = exp_s(MAZE_MAX, MAZE_MAX, 30, 0, 1, 0, 1, 0); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL goal_done: got %h want %h", got, want); end
    @(negedge clk);  // IDLE, arrived sticky
    got = snap(); want = exp_s(MAZE_MAX, MAZE_MAX, 30, 0, 1, 0, 0, 0); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL goal_idle: got %h want %h", got, want); end
    repeat (10) @(negedge clk);
    n_checks++;
    if (pops() !== 30) begin n_fail++; $display("FAIL goal_no_extra_pop: got %0d want 30", pops()); end
  endtask

  task automatic test_start_while_busy();
    clear_moves(); push_move(2'b01); push_move(2'b01);
    src_en = 1'b1;
    pulse_start();  // N0: arrived and step_count cleared
    got = snap(); want = exp_s(0, 0, 0, 1, 0, 0, 1, 1); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL busy_restart_clear: got %h want %h", got, want); end
    @(negedge clk);                 // N1 APPLY
    @(negedge clk); start = 1'b1;   // N2 HOLD
    @(negedge clk);                 // N3 FETCH, start still high
    @(negedge clk); start = 1'b0;   // N4 APPLY
    @(negedge clk);                 // N5
    got = snap(); want = exp_s(2, 0, 2, 1, 0, 0, 1, 0); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL busy_start_ignored: got %h want %h", got, want); end
    repeat (5) @(negedge clk);
    got = snap(); want = exp_s(2, 0, 2, 1, 0, 0, 0, 0); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL busy_settled: got %h want %h", got, want); end
  endtask

  task automatic test_bounds();
    do_reset();
    clear_moves(); push_move(2'b00);
    src_en = 1'b1;
    pulse_start();
    repeat (2) @(negedge clk);
    got = snap();
`ifdef RAT_PLAYER_BOUNDS_CHECK_EN
    want = exp_s(0, 0, 0, 0, 0, 1, 0, 0);
`else
    want = exp_s(0, MAZE_MAX, 1, 1, 0, 0, 1, 0);
`endif
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL bounds_apply: got %h want %h", got, want); end
    @(negedge clk);
    got = snap();
`ifdef RAT_PLAYER_BOUNDS_CHECK_EN
    want = exp_s(0, 0, 0, 0, 0, 1, 0, 0);
`else
    want = exp_s(0, MAZE_MAX, 1, 1, 0, 0, 0, 0);
`endif
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL bounds_after: got %h want %h", got, want); end
  endtask

  task automatic test_single_pop();
    n_checks++;
    if (consec_seen !== 1'b0) begin
      n_fail++; $display("FAIL single_pop: got back-to-back mv_ready=%b want 0", consec_seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic_replay();
    test_stall();
    test_reset_mid_hold();
    test_goal();
    test_start_while_busy();
    test_bounds();
    test_single_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
